// File: rtl/ble_rx_pkg.sv
// Shared types and constants for the BLE receive symbol-sync path.
package ble_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FLUSH = 3'd1,
      ST_ACQ   = 3'd2,
      ST_TRACK = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } sync_state_t;

   // Samples per symbol used by clock_recovery.
   localparam int DEFAULT_SAMPLE_RATE = 16;

   // Depth of the clock_recovery pipeline; symbol_clk is garbage until it fills.
   localparam int PIPELINE_STAGES = 9;

   // Bits needed to hold a counter that reaches max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/symbol_period_monitor.sv
// Measures symbol_clk intervals in samples, counts consecutive in-tolerance
// intervals and flags a missing symbol_clk (gap longer than two symbols).
module symbol_period_monitor
   import ble_rx_pkg::*;
#(
   parameter int SAMPLE_RATE = DEFAULT_SAMPLE_RATE,
   parameter int PERIOD_TOL  = 2,
   parameter int LOCK_SYMS   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic sample_valid,
   input  logic symbol_clk,
   output logic lock_met,
   output logic gap
);

   localparam int GAP_LIMIT = 2 * SAMPLE_RATE;
   localparam int IW = cnt_width(GAP_LIMIT + 1);
   localparam int GW = cnt_width(LOCK_SYMS);
   localparam logic [IW-1:0] I_MAX = {IW{1'b1}};
   localparam logic [GW-1:0] G_MAX = GW'(LOCK_SYMS);

   logic [IW-1:0] interval_reg;
   logic [IW-1:0] interval_cur;
   logic [GW-1:0] good_cnt_reg;
   logic          started_reg;
   logic          in_tol;

   // Interval including the current sample; saturates instead of wrapping.
   always_comb begin
      interval_cur = interval_reg;
      if (interval_reg != I_MAX) begin
         interval_cur = interval_reg + {{(IW-1){1'b0}}, sample_valid};
      end
      in_tol = (int'(interval_cur) >= SAMPLE_RATE - PERIOD_TOL) &&
               (int'(interval_cur) <= SAMPLE_RATE + PERIOD_TOL);
   end

   // Interval counter restarts on symbol_clk; the first symbol_clk only arms measurement.
   always_ff @(posedge clk) begin
      if (reset || !run) begin
         interval_reg <= '0;
         started_reg  <= 1'b0;
         good_cnt_reg <= '0;
      end else if (symbol_clk) begin
         interval_reg <= '0;
         started_reg  <= 1'b1;
         if (started_reg) begin
            if (!in_tol) begin
               good_cnt_reg <= '0;
            end else if (good_cnt_reg != G_MAX) begin
               good_cnt_reg <= good_cnt_reg + GW'(1);
            end
         end
      end else begin
         interval_reg <= interval_cur;
      end
   end

   assign lock_met = (good_cnt_reg == G_MAX);
   assign gap      = !symbol_clk && (int'(interval_cur) > GAP_LIMIT);

endmodule

// File: rtl/symbol_sync_ctrl.sv
// Symbol sync sequencing controller: restarts clock_recovery, waits out its
// pipeline, acquires timing lock, gates bit strobes through the payload.
// Optional packet statistics ports: define SYMBOL_SYNC_CTRL_STATS_EN.
module symbol_sync_ctrl
   import ble_rx_pkg::*;
#(
   parameter int SAMPLE_RATE   = DEFAULT_SAMPLE_RATE,
   parameter int FLUSH_SAMPLES = PIPELINE_STAGES,
   parameter int PERIOD_TOL    = 2,
   parameter int LOCK_SYMS     = 8,
   parameter int TIMEOUT_SYMS  = 64,
   parameter int LEN_W         = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_valid,
   input  logic             rx_start,
   input  logic             abort,
   input  logic             preamble_detected,
   input  logic             symbol_clk,
   input  logic [LEN_W-1:0] pkt_len,
   input  logic             pkt_len_valid,
   output logic             cr_en,
   output logic             cr_resetn,
   output logic             bit_strobe,
   output logic             locked,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [2:0]       state
`ifdef SYMBOL_SYNC_CTRL_STATS_EN
   ,
   output logic [7:0]       pkt_ok_cnt,
   output logic [7:0]       pkt_err_cnt
`endif
);

   localparam int TOUT = TIMEOUT_SYMS * SAMPLE_RATE;
   localparam int FW   = cnt_width(FLUSH_SAMPLES);
   localparam int TW   = cnt_width(TOUT);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_SAMPLES - 1);
   localparam logic [TW-1:0] TOUT_LAST  = TW'(TOUT - 1);
   localparam logic [TW-1:0] TOUT_MAX   = TW'(TOUT);

   sync_state_t      state_reg, state_next;
   logic [FW-1:0]    flush_cnt_reg;
   logic [TW-1:0]    to_cnt_reg;
   logic             pre_flag_reg;
   logic [LEN_W-1:0] bit_cnt_reg;
   logic [LEN_W-1:0] len_reg;
   logic             len_cap_reg;

   logic cr_en_reg, cr_en_next;
   logic cr_resetn_reg, cr_resetn_next;
   logic bit_strobe_reg, bit_strobe_next;
   logic locked_reg, locked_next;
   logic busy_reg, busy_next;
   logic done_reg, done_next;
   logic error_reg, error_next;

   logic run;
   logic lock_met;
   logic gap;
   logic timeout_hit;

   assign run = (state_reg == ST_ACQ) || (state_reg == ST_TRACK);

   symbol_period_monitor #(
      .SAMPLE_RATE (SAMPLE_RATE),
      .PERIOD_TOL  (PERIOD_TOL),
      .LOCK_SYMS   (LOCK_SYMS)
   ) u_period_mon (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .sample_valid (sample_valid),
      .symbol_clk   (symbol_clk),
      .lock_met     (lock_met),
      .gap          (gap)
   );

   assign timeout_hit = (state_reg == ST_ACQ) && sample_valid && (to_cnt_reg == TOUT_LAST);

   // Next-state and next-output logic; abort overrides every transition.
   always_comb begin
      state_next = state_reg;
      if (abort) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE:  if (rx_start) state_next = ST_FLUSH;
            ST_FLUSH: if (sample_valid && (flush_cnt_reg == FLUSH_LAST)) state_next = ST_ACQ;
            ST_ACQ: begin
               if (timeout_hit) begin
                  state_next = ST_ERR;
               end else if (lock_met && pre_flag_reg) begin
                  state_next = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (gap) begin
                  state_next = ST_ERR;
               end else if (bit_cnt_reg == len_reg) begin
                  state_next = ST_DONE;
               end
            end
            default:  state_next = ST_IDLE;
         endcase
      end

      cr_en_next      = sample_valid && ((state_next == ST_FLUSH) || (state_next == ST_ACQ) ||
                                         (state_next == ST_TRACK));
      cr_resetn_next  = !((state_reg == ST_IDLE) && (state_next == ST_FLUSH));
      bit_strobe_next = symbol_clk && (state_reg == ST_TRACK) && (state_next == ST_TRACK);
      locked_next     = (state_next == ST_TRACK);
      busy_next       = (state_next != ST_IDLE);
      done_next       = (state_next == ST_DONE);
      error_next      = (state_next == ST_ERR);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         cr_en_reg      <= 1'b0;
         cr_resetn_reg  <= 1'b1;
         bit_strobe_reg <= 1'b0;
         locked_reg     <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cr_en_reg      <= cr_en_next;
         cr_resetn_reg  <= cr_resetn_next;
         bit_strobe_reg <= bit_strobe_next;
         locked_reg     <= locked_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
         error_reg      <= error_next;
      end
   end

   // Pipeline-fill, timeout and preamble bookkeeping; cleared outside their states.
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_cnt_reg <= '0;
         to_cnt_reg    <= '0;
         pre_flag_reg  <= 1'b0;
      end else begin
         if (state_reg != ST_FLUSH) begin
            flush_cnt_reg <= '0;
         end else if (sample_valid) begin
            flush_cnt_reg <= flush_cnt_reg + FW'(1);
         end

         if (state_reg != ST_ACQ) begin
            to_cnt_reg <= '0;
         end else if (sample_valid && (to_cnt_reg != TOUT_MAX)) begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
         end

         if (state_reg == ST_IDLE) begin
            pre_flag_reg <= 1'b0;
         end else if ((state_reg == ST_ACQ) && preamble_detected) begin
            pre_flag_reg <= 1'b1;
         end
      end
   end

   // Payload length capture (first pulse per packet wins) and bit counting.
   always_ff @(posedge clk) begin
      if (reset || (state_reg == ST_IDLE)) begin
         bit_cnt_reg <= '0;
         len_reg     <= '1;
         len_cap_reg <= 1'b0;
      end else if (state_reg == ST_TRACK) begin
         if (bit_strobe_reg) begin
            bit_cnt_reg <= bit_cnt_reg + LEN_W'(1);
         end
         if (pkt_len_valid && !len_cap_reg) begin
            len_reg     <= pkt_len;
            len_cap_reg <= 1'b1;
         end
      end
   end

   assign cr_en      = cr_en_reg;
   assign cr_resetn  = cr_resetn_reg;
   assign bit_strobe = bit_strobe_reg;
   assign locked     = locked_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign error      = error_reg;
   assign state      = state_reg;

`ifdef SYMBOL_SYNC_CTRL_STATS_EN
   logic [7:0] ok_cnt_reg;
   logic [7:0] err_cnt_reg;

   // Saturating packet outcome counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ok_cnt_reg  <= '0;
         err_cnt_reg <= '0;
      end else begin
         if (done_reg && (ok_cnt_reg != 8'hFF)) begin
            ok_cnt_reg <= ok_cnt_reg + 8'd1;
         end
         if (error_reg && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
         end
      end
   end

   assign pkt_ok_cnt  = ok_cnt_reg;
   assign pkt_err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_symbol_sync_ctrl.sv
// Directed testbench for symbol_sync_ctrl with hand-computed cycle numbers.
// Cycle c = cycle in which rx_start is driven (c=0); values observed #1 after
// the edge that ends cycle c are the register values of cycle c+1.
module tb_symbol_sync_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic        rx_start;
   logic        abort;
   logic        preamble_detected;
   logic        symbol_clk;
   logic [11:0] pkt_len;
   logic        pkt_len_valid;
   logic        cr_en;
   logic        cr_resetn;
   logic        bit_strobe;
   logic        locked;
   logic        busy;
   logic        done;
   logic        error;
   logic [2:0]  state;
`ifdef SYMBOL_SYNC_CTRL_STATS_EN
   logic [7:0]  pkt_ok_cnt;
   logic [7:0]  pkt_err_cnt;
`endif

   always #5 clk = ~clk;

   symbol_sync_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .sample_valid      (sample_valid),
      .rx_start          (rx_start),
      .abort             (abort),
      .preamble_detected (preamble_detected),
      .symbol_clk        (symbol_clk),
      .pkt_len           (pkt_len),
      .pkt_len_valid     (pkt_len_valid),
      .cr_en             (cr_en),
      .cr_resetn         (cr_resetn),
      .bit_strobe        (bit_strobe),
      .locked            (locked),
      .busy              (busy),
      .done              (done),
      .error             (error),
`ifdef SYMBOL_SYNC_CTRL_STATS_EN
      .pkt_ok_cnt        (pkt_ok_cnt),
      .pkt_err_cnt       (pkt_err_cnt),
`endif
      .state             (state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int acq_cyc, lock_cyc, last_lock, first_stb, nstb, ndone, done_cyc, nerr, err_cyc;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rx_start          = 1'b0;
      abort             = 1'b0;
      preamble_detected = 1'b0;
      symbol_clk        = 1'b0;
      pkt_len_valid     = 1'b0;
      pkt_len           = 12'd0;
      sample_valid      = 1'b0;
   endtask

   // mode 0: normal 24-bit packet, 1: 16/19 alternating intervals (timeout),
   // 2: symbol_clk stops in TRACK, 3: abort+rx_start mid-TRACK, 4: zero-length packet
   task automatic run_pkt(input int mode, input int ncyc);
      int nxt_clk;
      bit alt;
      int oc;
      acq_cyc = -1; lock_cyc = -1; last_lock = -1; first_stb = -1;
      nstb = 0; ndone = 0; done_cyc = -1; nerr = 0; err_cyc = -1;
      nxt_clk = 16;
      alt = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         rx_start          = (c == 0) || (mode == 3 && (c == 208 || c == 209));
         abort             = (mode == 3 && c == 208);
         sample_valid      = 1'b1;
         preamble_detected = (c == 40);
         if (mode == 1) begin
            symbol_clk = (c == nxt_clk);
            if (c == nxt_clk) begin
               nxt_clk = nxt_clk + (alt ? 19 : 16);
               alt = !alt;
            end
         end else begin
            symbol_clk = ((c % 16) == 0) && !(mode == 2 && c > 240);
         end
         pkt_len_valid = (mode == 0 && (c == 150 || c == 200)) || (mode == 4);
         pkt_len       = (mode == 4) ? 12'd0 : ((c == 150) ? 12'd24 : 12'd5);
         tick();
         oc = c + 1;
         if (state == 3'd2 && acq_cyc < 0) acq_cyc = oc;
         if (locked) begin
            if (lock_cyc < 0) lock_cyc = oc;
            last_lock = oc;
         end
         if (bit_strobe) begin
            nstb++;
            if (first_stb < 0) first_stb = oc;
         end
         if (done) begin
            ndone++;
            done_cyc = oc;
         end
         if (error) begin
            nerr++;
            err_cyc = oc;
         end
         if (mode == 0 && oc == 1) begin
            chk("start_state", int'(state), 1);
            chk("start_cr_resetn", int'(cr_resetn), 0);
            chk("start_cr_en", int'(cr_en), 1);
            chk("start_busy", int'(busy), 1);
         end
         if (mode == 0 && oc == 2) chk("flush2_cr_resetn", int'(cr_resetn), 1);
         if (mode == 3 && oc == 209) begin
            chk("abort_state", int'(state), 0);
            chk("abort_locked", int'(locked), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_cr_en", int'(cr_en), 0);
            chk("abort_cr_resetn", int'(cr_resetn), 1);
            chk("abort_bit_strobe", int'(bit_strobe), 0);
         end
         if (mode == 3 && oc == 210) begin
            chk("restart_state", int'(state), 1);
            chk("restart_cr_resetn", int'(cr_resetn), 0);
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("rst_cr_en", int'(cr_en), 0);
      chk("rst_cr_resetn", int'(cr_resetn), 1);
      chk("rst_bit_strobe", int'(bit_strobe), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_state", int'(state), 0);

      // Normal packet: ACQ at 10, lock after 9th ACQ symbol_clk (c=144),
      // first strobe c=161, 24 strobes, done at 531.
      run_pkt(0, 560);
      chk("pkt_acq_cycle", acq_cyc, 10);
      chk("pkt_lock_cycle", lock_cyc, 146);
      chk("pkt_first_strobe", first_stb, 161);
      chk("pkt_strobes", nstb, 24);
      chk("pkt_done_pulses", ndone, 1);
      chk("pkt_done_cycle", done_cyc, 531);
      chk("pkt_last_locked", last_lock, 530);
      chk("pkt_errors", nerr, 0);
      chk("pkt_end_state", int'(state), 0);
      chk("pkt_end_busy", int'(busy), 0);
      for (int i = 0; i < 3; i++) tick();

      // Alternating 16/19 intervals: never locks, timeout after 1024 ACQ samples.
      run_pkt(1, 1060);
      chk("alt_lock_cycle", lock_cyc, -1);
      chk("alt_errors", nerr, 1);
      chk("alt_err_cycle", err_cyc, 1034);
      chk("alt_done", ndone, 0);
      chk("alt_end_state", int'(state), 0);
      for (int i = 0; i < 3; i++) tick();

      // symbol_clk stops after c=240: gap of 33 samples -> error at 274.
      run_pkt(2, 300);
      chk("gap_lock_cycle", lock_cyc, 146);
      chk("gap_strobes", nstb, 6);
      chk("gap_err_cycle", err_cyc, 274);
      chk("gap_last_locked", last_lock, 273);
      chk("gap_done", ndone, 0);
      chk("gap_locked_after", int'(locked), 0);
      for (int i = 0; i < 3; i++) tick();

      // abort with rx_start at c=208, second rx_start at c=209.
      run_pkt(3, 215);
      chk("abort_strobes", nstb, 3);
      chk("abort_done", ndone, 0);
      chk("abort_errors", nerr, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int i = 0; i < 3; i++) tick();

      // Zero-length packet: captured at c=146, done on the cycle after capture.
      run_pkt(4, 155);
      chk("zero_lock_cycle", lock_cyc, 146);
      chk("zero_done_cycle", done_cyc, 148);
      chk("zero_done_pulses", ndone, 1);
      chk("zero_strobes", nstb, 0);
      for (int i = 0; i < 3; i++) tick();

`ifdef SYMBOL_SYNC_CTRL_STATS_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("stats_rst_ok", int'(pkt_ok_cnt), 0);
      for (int p = 0; p < 300; p++) begin
         run_pkt(4, 152);
         tick();
      end
      chk("stats_ok_sat", int'(pkt_ok_cnt), 255);
      chk("stats_err_zero", int'(pkt_err_cnt), 0);
      run_pkt(1, 1060);
      tick();
      chk("stats_err_one", int'(pkt_err_cnt), 1);
      chk("stats_ok_hold", int'(pkt_ok_cnt), 255);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
